// File: rtl/ga_pkg.sv
// Shared defaults and edge-detector lane assignments for the gate-array interrupt logic.
package ga_pkg;

    localparam int LINES_PER_INT_DEF = 52;
    localparam int CNT_W_DEF         = 6;
    localparam int VSYNC_DELAY_DEF   = 2;
    localparam int VSYNC_THRESH_DEF  = 32;
    localparam int LINE_W_DEF        = 9;
    localparam int VBLANK_LINES_DEF  = 26;

    // Lanes of the shared edge detector: hsync and intack want falls, vsync wants rises.
    localparam int EDGE_W   = 3;
    localparam int EDGE_HS  = 0;
    localparam int EDGE_VS  = 1;
    localparam int EDGE_ACK = 2;
    localparam logic [EDGE_W-1:0] EDGE_RISE_MASK = 3'b010;

    typedef struct packed {
        logic ack_fall;
        logic vs_rise;
        logic hs_fall;
    } edge_evt_t;

endpackage

// File: rtl/ga_edge_det.sv
// Registered edge detector: each lane reports a rise or a fall against the previous sample.
module ga_edge_det #(
    parameter int             N         = 1,
    parameter logic [N-1:0]   RISE_MASK = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] d,
    output logic [N-1:0] pulse
);

    logic [N-1:0] d_p0;

    always_ff @(posedge clk) begin
        if (reset) begin
            d_p0 <= '0;
        end else begin
            d_p0 <= d;
        end
    end

    assign pulse = (RISE_MASK & ~d_p0 & d) | (~RISE_MASK & d_p0 & ~d);

endmodule

// File: rtl/ga_int_ctrl.sv
// Raster interrupt controller: periodic 52-line interrupt with VSYNC resync,
// optional programmable raster line, scanline counter and vblank flag.
module ga_int_ctrl import ga_pkg::*; #(
    parameter int LINES_PER_INT = LINES_PER_INT_DEF,
    parameter int CNT_W         = CNT_W_DEF,
    parameter int VSYNC_DELAY   = VSYNC_DELAY_DEF,
    parameter int VSYNC_THRESH  = VSYNC_THRESH_DEF,
    parameter int LINE_W        = LINE_W_DEF,
    parameter int VBLANK_LINES  = VBLANK_LINES_DEF
) (
    input  logic              ck16,
    input  logic              reset,
    input  logic              hsync,
    input  logic              vsync,
    input  logic              intack,
    input  logic              clr_int,
    input  logic              pri_wr,
    input  logic [LINE_W-1:0] pri_line,
    output logic              int_n,
    output logic [CNT_W-1:0]  intcnt,
    output logic [LINE_W-1:0] line,
    output logic              vblank,
    output logic              pri_mode
);

    localparam int VCNT_W = (VSYNC_DELAY < 1) ? 1 : $clog2(VSYNC_DELAY + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(LINES_PER_INT - 1);
    localparam logic [CNT_W-1:0]  CNT_THRESH = CNT_W'(VSYNC_THRESH);
    localparam logic [VCNT_W-1:0] VCNT_IDLE  = VCNT_W'(VSYNC_DELAY);
    localparam logic [VCNT_W-1:0] VCNT_LAST  = VCNT_W'(VSYNC_DELAY - 1);
    localparam logic [LINE_W-1:0] LINE_VBL   = LINE_W'(VBLANK_LINES);

    function automatic logic [LINE_W-1:0] sat_inc_line(input logic [LINE_W-1:0] v);
        return (&v) ? v : v + LINE_W'(1);
    endfunction

    logic [EDGE_W-1:0] ev;
    edge_evt_t         evt;

    logic [VCNT_W-1:0] vcnt, vcnt_nxt;
    logic [LINE_W-1:0] pri_reg, pri_nxt;
    logic [LINE_W-1:0] line_nxt, line_inc;
    logic [CNT_W-1:0]  cnt_nxt, cnt_acked;
    logic              int_n_nxt, vblank_nxt, int_set, resync;

    ga_edge_det #(
        .N         (EDGE_W),
        .RISE_MASK (EDGE_RISE_MASK)
    ) u_edge (
        .clk   (ck16),
        .reset (reset),
        .d     ({intack, vsync, hsync}),
        .pulse (ev)
    );

    assign evt.hs_fall  = ev[EDGE_HS];
    assign evt.vs_rise  = ev[EDGE_VS];
    assign evt.ack_fall = ev[EDGE_ACK];

    assign pri_mode = |pri_reg;

    always_comb begin
        cnt_acked  = intcnt;
        line_inc   = sat_inc_line(line);
        vcnt_nxt   = vcnt;
        line_nxt   = line;
        vblank_nxt = vblank;
        pri_nxt    = pri_wr ? pri_line : pri_reg;
        int_set    = 1'b0;
        int_n_nxt  = int_n;

        // The acknowledge clears the top bit before any same-cycle hsync step sees it.
        if (evt.ack_fall) begin
            cnt_acked[CNT_W-1] = 1'b0;
        end
        cnt_nxt = cnt_acked;

        resync = evt.hs_fall && !evt.vs_rise && (vcnt == VCNT_LAST);

        if (evt.vs_rise) begin
            vcnt_nxt   = '0;
            line_nxt   = '0;
            vblank_nxt = 1'b1;
        end else if (evt.hs_fall) begin
            if (vcnt < VCNT_IDLE) begin
                vcnt_nxt = vcnt + VCNT_W'(1);
            end
            line_nxt = line_inc;
            if (line_inc == LINE_VBL) begin
                vblank_nxt = 1'b0;
            end
        end

        if (evt.hs_fall) begin
            if (resync) begin
                cnt_nxt = '0;
                int_set = !pri_mode && (cnt_acked >= CNT_THRESH);
            end else if (cnt_acked == CNT_LAST) begin
                cnt_nxt = '0;
                int_set = !pri_mode;
            end else begin
                cnt_nxt = cnt_acked + CNT_W'(1);
            end
        end

        if (pri_mode && evt.hs_fall && !evt.vs_rise && (line_inc == pri_reg)) begin
            int_set = 1'b1;
        end

        if (evt.ack_fall) begin
            int_n_nxt = 1'b1;
        end
        if (int_set) begin
            int_n_nxt = 1'b0;
        end

        if (clr_int) begin
            cnt_nxt   = '0;
            int_n_nxt = 1'b1;
        end
    end

    always_ff @(posedge ck16) begin
        if (reset) begin
            int_n   <= 1'b1;
            intcnt  <= '0;
            line    <= '1;
            vblank  <= 1'b0;
            pri_reg <= '0;
            vcnt    <= VCNT_IDLE;
        end else begin
            int_n   <= int_n_nxt;
            intcnt  <= cnt_nxt;
            line    <= line_nxt;
            vblank  <= vblank_nxt;
            pri_reg <= pri_nxt;
            vcnt    <= vcnt_nxt;
        end
    end

endmodule

// File: tb/tb_ga_int_ctrl.sv
// Scoreboard bench for ga_int_ctrl: stimulus queues expected states and int_n falls, monitor compares.
module tb_ga_int_ctrl;

    logic       ck16     = 1'b0;
    logic       reset    = 1'b1;
    logic       hsync    = 1'b0;
    logic       vsync    = 1'b0;
    logic       intack   = 1'b0;
    logic       clr_int  = 1'b0;
    logic       pri_wr   = 1'b0;
    logic [8:0] pri_line = '0;
    logic       int_n;
    logic [5:0] intcnt;
    logic [8:0] line;
    logic       vblank;
    logic       pri_mode;

    ga_int_ctrl dut (
        .ck16     (ck16),
        .reset    (reset),
        .hsync    (hsync),
        .vsync    (vsync),
        .intack   (intack),
        .clr_int  (clr_int),
        .pri_wr   (pri_wr),
        .pri_line (pri_line),
        .int_n    (int_n),
        .intcnt   (intcnt),
        .line     (line),
        .vblank   (vblank),
        .pri_mode (pri_mode)
    );

    always #5 ck16 = ~ck16;

    int cyc = 0;
    always @(posedge ck16) cyc <= cyc + 1;

    typedef struct {
        string name;
        int    cyc;
        int    int_n;
        int    intcnt;
        int    line;
        int    vblank;
        int    pri_mode;
    } exp_t;

    exp_t exp_q[$];
    int   fall_q[$];
    int   n_chk = 0;
    int   n_bad = 0;

    task automatic step();
        @(posedge ck16);
        #1;
    endtask

    task automatic expect_st(input string name, input int i_n, input int cnt,
                             input int ln, input int vb, input int pm);
        exp_t e;
        e.name     = name;
        e.cyc      = cyc;
        e.int_n    = i_n;
        e.intcnt   = cnt;
        e.line     = ln;
        e.vblank   = vb;
        e.pri_mode = pm;
        exp_q.push_back(e);
    endtask

    task automatic expect_fall();
        fall_q.push_back(cyc);
    endtask

    task automatic hs_pulse();
        hsync = 1'b1;
        step();
        hsync = 1'b0;
        step();
    endtask

    task automatic ack_pulse();
        intack = 1'b1;
        step();
        intack = 1'b0;
        step();
    endtask

    // Monitor: int_n falls are matched against the fall queue, state snapshots against exp_q.
    logic int_n_q = 1'b1;
    exp_t e_m;
    int   c_m;
    bit   ok_m;
    always @(negedge ck16) begin
        if (int_n_q === 1'b1 && int_n === 1'b0) begin
            n_chk++;
            if (fall_q.size() == 0) begin
                n_bad++;
                $display("FAIL int_n_fall: unexpected fall at cycle %0d, required no fall", cyc);
            end else begin
                c_m = fall_q.pop_front();
                if (c_m != cyc) begin
                    n_bad++;
                    $display("FAIL int_n_fall: fall at cycle %0d, required cycle %0d", cyc, c_m);
                end
            end
        end
        int_n_q = int_n;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e_m = exp_q.pop_front();
            n_chk++;
            ok_m = (e_m.cyc == cyc) && (int_n === 1'(e_m.int_n));
            if (e_m.intcnt   >= 0 && intcnt   !== 6'(e_m.intcnt))   ok_m = 1'b0;
            if (e_m.line     >= 0 && line     !== 9'(e_m.line))     ok_m = 1'b0;
            if (e_m.vblank   >= 0 && vblank   !== 1'(e_m.vblank))   ok_m = 1'b0;
            if (e_m.pri_mode >= 0 && pri_mode !== 1'(e_m.pri_mode)) ok_m = 1'b0;
            if (!ok_m) begin
                n_bad++;
                $display("FAIL %s: got int_n=%0b intcnt=%0d line=%0d vblank=%0b pri_mode=%0b cyc=%0d, required int_n=%0d intcnt=%0d line=%0d vblank=%0d pri_mode=%0d cyc=%0d",
                         e_m.name, int_n, intcnt, line, vblank, pri_mode, cyc,
                         e_m.int_n, e_m.intcnt, e_m.line, e_m.vblank, e_m.pri_mode, e_m.cyc);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required self-termination");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        reset = 1'b1;
        step();
        step();
        expect_st("reset", 1, 0, 511, 0, 0);
        reset = 1'b0;
        step();

        // Periodic interrupts after 52 and 104 hsync falls, no vsync
        for (int i = 1; i <= 104; i++) begin
            hs_pulse();
            if (i == 52 || i == 104) begin
                expect_fall();
                expect_st($sformatf("periodic_%0d", i), 0, 0, 511, 0, 0);
                ack_pulse();
                expect_st($sformatf("periodic_ack_%0d", i), 1, 0, 511, 0, 0);
            end else if (i == 1 || i == 51 || i == 103) begin
                expect_st($sformatf("count_%0d", i), 1, i % 52, 511, 0, 0);
            end
        end

        // Pending interrupt, count to 40, acknowledge clears bit 5
        for (int i = 1; i <= 92; i++) begin
            hs_pulse();
            if (i == 52) begin
                expect_fall();
                expect_st("pend_int", 0, 0, 511, 0, 0);
            end
        end
        expect_st("pend_40", 0, 40, 511, 0, 0);
        intack = 1'b1;
        step();
        expect_st("ack_rise_hold", 0, 40, 511, 0, 0);
        intack = 1'b0;
        step();
        expect_st("ack_fall_clear", 1, 8, 511, 0, 0);

        // VSYNC resync above threshold
        reset = 1'b1;
        step();
        expect_st("reset_again", 1, 0, 511, 0, 0);
        reset = 1'b0;
        step();
        repeat (35) hs_pulse();
        expect_st("pre_vs_35", 1, 35, 511, 0, 0);
        vsync = 1'b1;
        step();
        vsync = 1'b0;
        expect_st("vs_rise_35", 1, 35, 0, 1, 0);
        hs_pulse();
        expect_st("resync_first_35", 1, 36, 1, 1, 0);
        hs_pulse();
        expect_fall();
        expect_st("resync_hi", 0, 0, 2, 1, 0);
        ack_pulse();
        expect_st("resync_hi_ack", 1, 0, 2, 1, 0);

        // VSYNC resync below threshold, then vblank end
        repeat (20) hs_pulse();
        expect_st("pre_vs_20", 1, 20, 22, 1, 0);
        vsync = 1'b1;
        step();
        vsync = 1'b0;
        expect_st("vs_rise_20", 1, 20, 0, 1, 0);
        hs_pulse();
        hs_pulse();
        expect_st("resync_lo", 1, 0, 2, 1, 0);
        for (int k = 3; k <= 26; k++) begin
            hs_pulse();
            if (k == 25) expect_st("vblank_hold", 1, 23, 25, 1, 0);
            if (k == 26) expect_st("vblank_end", 1, 24, 26, 0, 0);
        end

        // clr_int coincident with the wrapping hsync fall
        repeat (27) hs_pulse();
        expect_st("pre_clr_51", 1, 51, 53, 0, 0);
        hsync = 1'b1;
        step();
        hsync = 1'b0;
        clr_int = 1'b1;
        step();
        clr_int = 1'b0;
        expect_st("clr_vs_wrap", 1, 0, 54, 0, 0);

        // Programmable raster line 100
        pri_line = 9'd100;
        pri_wr = 1'b1;
        step();
        pri_wr = 1'b0;
        expect_st("pri_wr", 1, 0, 54, 0, 1);
        vsync = 1'b1;
        step();
        vsync = 1'b0;
        expect_st("pri_vs_rise", 1, 0, 0, 1, 1);
        for (int k = 1; k <= 120; k++) begin
            hs_pulse();
            if (k == 54) expect_st("pri_no_periodic", 1, 0, 54, 0, 1);
            if (k == 99) expect_st("pri_line_99", 1, 45, 99, 0, 1);
            if (k == 100) begin
                expect_fall();
                expect_st("pri_line_100", 0, 46, 100, 0, 1);
            end
            if (k == 120) expect_st("pri_line_120", 0, 14, 120, 0, 1);
        end

        // Reset in the middle of the frame, coincident with an hsync fall
        repeat (30) hs_pulse();
        expect_st("line_150", 0, 44, 150, 0, 1);
        hsync = 1'b1;
        step();
        hsync = 1'b0;
        reset = 1'b1;
        step();
        expect_st("mid_reset", 1, 0, 511, 0, 0);
        reset = 1'b0;
        hsync = 1'b1;
        step();
        hsync = 1'b0;
        step();
        expect_st("post_reset_fall", 1, 1, 511, 0, 0);

        step();
        step();
        n_chk++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain_exp: %0d expectations left, required 0", exp_q.size());
        end
        n_chk++;
        if (fall_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain_fall: %0d expected int_n falls not seen, required 0", fall_q.size());
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
